upsize_pack_pipe: RTL

- Narrow-to-wide packing stage upstream of the backward/forward pipe on DATA_W-wide streams.
- Collects RATIO narrow beats of IN_W bits into one OUT_W = IN_W*RATIO word and presents it on a registered valid/ready output.
- A packet-end marker (last) flushes a partial word early with a per-lane keep mask.
- Typical use: 32-bit producer (DMA/regfile) feeding a 256-bit pipeline, with IN_W=32 and RATIO=8.

---
 rtl/upsize_pack_pipe.sv | 114 +++++++++++
 1 files changed

// File: rtl/upsize_pack_pipe.sv
// Narrow-to-wide packer: gathers RATIO beats of IN_W bits into one wide word,
// flushing early on f_last_in, and holds the result in a registered valid/ready stage.
module upsize_pack_pipe #(
   parameter int IN_W  = 32,
   parameter int RATIO = 8,
   localparam int OUT_W = IN_W * RATIO
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             f_valid_in,
   input  logic [IN_W-1:0]  f_data_in,
   input  logic             f_last_in,
   output logic             f_ready_out,
   output logic             b_valid_out,
   output logic [OUT_W-1:0] b_data_out,
   output logic [RATIO-1:0] b_keep_out,
   output logic             b_last_out,
   input  logic             b_ready_in
);

   localparam int CNT_W = $clog2(RATIO);
   localparam int unsigned RATIO_U   = RATIO;
   localparam int unsigned LAST_LANE = RATIO - 1;

   logic [OUT_W-1:0] acc_data_q, acc_data_d;
   logic [RATIO-1:0] acc_keep_q, acc_keep_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             b_valid_q, b_valid_d;
   logic [OUT_W-1:0] b_data_q, b_data_d;
   logic [RATIO-1:0] b_keep_q, b_keep_d;
   logic             b_last_q, b_last_d;

   logic             in_fire;
   logic             out_fire;
   logic             complete;
   int unsigned      cnt_u;
   logic [OUT_W-1:0] merged_data;
   logic [RATIO-1:0] merged_keep;

   assign f_ready_out = ~b_valid_q | b_ready_in;
   assign in_fire     = f_valid_in & f_ready_out;
   assign out_fire    = b_valid_q & b_ready_in;

   assign b_valid_out = b_valid_q;
   assign b_data_out  = b_data_q;
   assign b_keep_out  = b_keep_q;
   assign b_last_out  = b_last_q;

   // Accumulator with lane cnt replaced by the incoming beat; lanes above cnt
   // are forced to zero so the same value serves as next accumulator and as
   // the flushed output word.
   always_comb begin
      cnt_u       = 32'(cnt_q);
      merged_data = '0;
      merged_keep = '0;
      for (int unsigned i = 0; i < RATIO_U; i++) begin
         if (i < cnt_u) begin
            merged_data[i*IN_W +: IN_W] = acc_data_q[i*IN_W +: IN_W];
            merged_keep[i]              = acc_keep_q[i];
         end else if (i == cnt_u) begin
            merged_data[i*IN_W +: IN_W] = f_data_in;
            merged_keep[i]              = 1'b1;
         end
      end
   end

   assign complete = in_fire & ((cnt_u == LAST_LANE) | f_last_in);

   always_comb begin
      acc_data_d = acc_data_q;
      acc_keep_d = acc_keep_q;
      cnt_d      = cnt_q;
      b_valid_d  = b_valid_q & ~out_fire;
      b_data_d   = b_data_q;
      b_keep_d   = b_keep_q;
      b_last_d   = b_last_q;

      if (complete) begin
         b_valid_d  = 1'b1;
         b_data_d   = merged_data;
         b_keep_d   = merged_keep;
         b_last_d   = f_last_in;
         acc_data_d = '0;
         acc_keep_d = '0;
         cnt_d      = '0;
      end else if (in_fire) begin
         acc_data_d = merged_data;
         acc_keep_d = merged_keep;
         cnt_d      = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_data_q <= '0;
         acc_keep_q <= '0;
         cnt_q      <= '0;
         b_valid_q  <= 1'b0;
         b_data_q   <= '0;
         b_keep_q   <= '0;
         b_last_q   <= 1'b0;
      end else begin
         acc_data_q <= acc_data_d;
         acc_keep_q <= acc_keep_d;
         cnt_q      <= cnt_d;
         b_valid_q  <= b_valid_d;
         b_data_q   <= b_data_d;
         b_keep_q   <= b_keep_d;
         b_last_q   <= b_last_d;
      end
   end

endmodule
